unsigned_div: RTL and testbench

- Iterative unsigned divider; the inverse of the combinational 24x24 unsigned multiplier in the fused-FP datapath.
- Takes a 2*WIDTH-bit dividend (a product or a left-shifted mantissa) and a WIDTH-bit divisor. Returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Multi-cycle restoring divider with valid/ready handshakes on both sides; feeds the FP divide/normalise stage.

---
 rtl/unsigned_div_pkg.sv | 22 ++
 rtl/unsigned_div_step.sv | 21 ++
 rtl/unsigned_div.sv | 156 +++++++++++++++
 tb/tb_unsigned_div.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_div_pkg.sv
// Shared types and elaboration-time helpers for the iterative unsigned divider.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_iters(input int width, input int bpc);
    return (2 * width) / bpc;
  endfunction

  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(calc_iters(width, bpc) + 1);
  endfunction

  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (((2 * width) % bpc) == 0);
  endfunction

endpackage

// File: rtl/unsigned_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] diff;

  // One extra bit above r_shift turns the subtraction borrow into the compare result.
  assign r_shift = {r, bit_in};
  assign diff    = r_shift - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign r_next  = q_bit ? diff[WIDTH:0] : r_shift[WIDTH:0];

endmodule

// File: rtl/unsigned_div.sv
// Multi-cycle restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// BITS_PER_CYCLE quotient bits per clock. Handshake: a transfer happens on a rising
// edge where valid and ready are both high; valid holds its payload until accepted.
module unsigned_div
  import unsigned_div_pkg::*;
#(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2*WIDTH-1:0]   DIVIDEND,
  input  logic [WIDTH-1:0]     DIVISOR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   QUOTIENT,
  output logic [WIDTH-1:0]     REMAINDER,
  output logic                 DIV_BY_ZERO
);

  localparam int N  = calc_iters(WIDTH, BITS_PER_CYCLE);
  localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);

  if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("unsigned_div: BITS_PER_CYCLE must be 1, 2 or 4 and divide 2*WIDTH");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [2*WIDTH-1:0]   quo_q, quo_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH:0]          chain_r [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [2*WIDTH-1:0]      quo_next;

  assign chain_r[0] = rem_q;

  // Steps are chained MSB first; the first step consumes the top dividend bit.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .r       (chain_r[i]),
      .bit_in  (dvd_q[2*WIDTH-1-i]),
      .divisor (dsr_q),
      .r_next  (chain_r[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  assign quo_next = (quo_q << BITS_PER_CYCLE) | {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, q_bits};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (IN_VALID && in_ready_q) begin
          dvd_d      = DIVIDEND;
          dsr_d      = DIVISOR;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CW'(N);
          dbz_d      = 1'b0;
          in_ready_d = 1'b0;
          if (DIVISOR == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = DIVIDEND[WIDTH-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_q << BITS_PER_CYCLE;
        rem_d = chain_r[BITS_PER_CYCLE];
        quo_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = quo_next;
          remainder_d = chain_r[BITS_PER_CYCLE][WIDTH-1:0];
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign QUOTIENT    = quotient_q;
  assign REMAINDER   = remainder_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_unsigned_div.sv
// Scoreboard bench for unsigned_div: one instance at 1 bit/cycle and one at 2 bits/cycle,
// fed identical operands and checked against plain '/' and '%' arithmetic.
module tb_unsigned_div;

  localparam int W    = 24;
  localparam int RW   = 1 + 2*W + W;   // {div_by_zero, quotient, remainder}
  localparam int LAT0 = 48;            // 2*W / 1
  localparam int LAT1 = 24;            // 2*W / 2

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_ready;

  logic           in_ready_a, out_valid_a, dbz_a;
  logic [2*W-1:0] quotient_a;
  logic [W-1:0]   remainder_a;
  logic           in_ready_b, out_valid_b, dbz_b;
  logic [2*W-1:0] quotient_b;
  logic [W-1:0]   remainder_b;

  logic [RW-1:0]  exp_q [2][$];
  int             acc_q [2][$];
  logic           prev_ov [2];

  int n_checks;
  int n_errors;
  int cyc;
  int rdy_mode;   // 0: always ready, 1: random, 2: held at rdy_val
  logic rdy_val;

  unsigned_div #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_a),
    .DIVIDEND(dividend), .DIVISOR(divisor), .OUT_VALID(out_valid_a),
    .OUT_READY(out_ready), .QUOTIENT(quotient_a), .REMAINDER(remainder_a),
    .DIV_BY_ZERO(dbz_a)
  );

  unsigned_div #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut_b (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_b),
    .DIVIDEND(dividend), .DIVISOR(divisor), .OUT_VALID(out_valid_b),
    .OUT_READY(out_ready), .QUOTIENT(quotient_b), .REMAINDER(remainder_b),
    .DIV_BY_ZERO(dbz_b)
  );

  // Clock / reset / cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = rdy_val;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Reference model
  function automatic logic [RW-1:0] model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    logic [2*W-1:0] q;
    logic [2*W-1:0] r;
    if (dv == '0) return {1'b1, {(2*W){1'b1}}, dd[W-1:0]};
    q = dd / {{W{1'b0}}, dv};
    r = dd % {{W{1'b0}}, dv};
    return {1'b0, q, r[W-1:0]};
  endfunction

  // Scoreboard monitor
  task automatic mon(input int id, input logic ov, input logic ir, input logic [2*W-1:0] q,
                     input logic [W-1:0] r, input logic dbz, input int lat_full);
    logic [RW-1:0] e;
    int lat;
    if (ov) begin
      if (exp_q[id].size() == 0) begin
        fail($sformatf("spurious_result_%0d", id));
      end else begin
        e = exp_q[id][0];
        check($sformatf("quotient_%0d", id), 64'(q), 64'(e[RW-2:W]));
        check($sformatf("remainder_%0d", id), 64'(r), 64'(e[W-1:0]));
        check($sformatf("div_by_zero_%0d", id), 64'(dbz), 64'(e[RW-1]));
        check($sformatf("in_ready_in_done_%0d", id), 64'(ir), 64'd0);
        if (!prev_ov[id]) begin
          // Divide-by-zero is presented in the cycle right after the accept edge.
          lat = e[RW-1] ? 0 : lat_full;
          check($sformatf("latency_%0d", id), 64'(cyc - acc_q[id][0]), 64'(lat));
        end
        if (out_ready) begin
          void'(exp_q[id].pop_front());
          void'(acc_q[id].pop_front());
        end
      end
    end
    prev_ov[id] = ov;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov[0] = 1'b0;
      prev_ov[1] = 1'b0;
    end else begin
      mon(0, out_valid_a, in_ready_a, quotient_a, remainder_a, dbz_a, LAT0);
      mon(1, out_valid_b, in_ready_b, quotient_b, remainder_b, dbz_b, LAT1);
    end
  end

  // Driver tasks
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    logic [RW-1:0] e;
    int t;
    t = 0;
    @(negedge clk);
    while (!(in_ready_a && in_ready_b) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      fail("issue_wait_ready");
      return;
    end
    e = model(dd, dv);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].push_back(e);
      acc_q[i].push_back(cyc + 1);
    end
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      acc_q[i].delete();
    end
  endtask

  initial begin
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    int t;
    n_checks  = 0;
    n_errors  = 0;
    rdy_mode  = 0;
    rdy_val   = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    prev_ov[0] = 1'b0;
    prev_ov[1] = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd0);
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_quotient_a", 64'(quotient_a), 64'd0);
    check("rst_remainder_a", 64'(remainder_a), 64'd0);
    check("rst_dbz_a", 64'(dbz_a), 64'd0);
    check("rst_quotient_b", 64'(quotient_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("post_rst_in_ready_b", 64'(in_ready_b), 64'd1);

    // Directed vectors
    issue(48'd100, 24'd7);
    issue(48'hFFFFFE000001, 24'hFFFFFF);
    issue(48'hFFFFFFFFFFFF, 24'd1);
    issue(48'hFFFFFFFFFFFF, 24'h800000);
    issue(48'h123456ABCDEF, 24'd0);

    // Backpressure: result held, new operands ignored
    rdy_mode = 2;
    rdy_val  = 1'b0;
    issue(48'd100, 24'd7);
    t = 0;
    while (!out_valid_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("hold_wait_valid");
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 48'd5;
      divisor  = 24'd1;
      check("hold_in_ready_a", 64'(in_ready_a), 64'd0);
      check("hold_in_ready_b", 64'(in_ready_b), 64'd0);
      check("hold_out_valid_a", 64'(out_valid_a), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_val  = 1'b1;
    t = 0;
    while (out_valid_a && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) fail("release_wait");
    check("release_in_ready_a", 64'(in_ready_a), 64'd1);
    check("release_in_ready_b", 64'(in_ready_b), 64'd1);
    issue(48'd1000, 24'd10);
    rdy_mode = 0;

    // Reset in the middle of a divide
    issue(48'd1234567, 24'd89);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("midrst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("midrst_in_ready_a", 64'(in_ready_a), 64'd0);
    check("midrst_in_ready_b", 64'(in_ready_b), 64'd0);
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(in_ready_a && in_ready_b) && t < 5) begin
      @(negedge clk);
      t++;
    end
    check("midrst_release_in_ready_a", 64'(in_ready_a), 64'd1);
    check("midrst_release_in_ready_b", 64'(in_ready_b), 64'd1);
    issue(48'd9, 24'd3);

    // Randomized operands with random output backpressure
    rdy_mode = 1;
    for (int n = 0; n < 30; n++) begin
      dd = {16'($urandom), 32'($urandom)};
      case ($urandom_range(0, 4))
        0:       dv = '0;
        1:       dv = 24'($urandom_range(1, 15));
        2:       dv = 24'($urandom);
        3:       dv = 24'hFFFFFF;
        default: begin
          dv = 24'($urandom) | 24'h1;
          dd = {24'd0, 24'($urandom)};
        end
      endcase
      issue(dd, dv);
    end

    // Drain
    rdy_mode = 0;
    t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail("drain_timeout");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
